lfsr_burst_ctrl: RTL

LFSR_BURST_CTRL -- requirements
Module: lfsr_burst_ctrl

---
 rtl/lfsr_burst_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/lfsr_burst_ctrl.sv
// Burst word generator: streams cmd_len words from a 26-bit LFSR
// over a valid/ready output, one step per accepted word.
module lfsr_burst_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:26]      cmd_seed,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:26]      out_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:26]      r_lfsr;
  logic [1:26]      w_lfsr_nxt;
  logic [1:26]      w_step;
  logic [1:26]      w_seed;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_rem_nxt;

  // all-zero register would lock up; restart from bit 26
  always_comb begin
    if (r_lfsr == '0) begin
      w_step = 26'd1;
    end else begin
      w_step = {r_lfsr[26],
                r_lfsr[1] ^ r_lfsr[26],
                r_lfsr[2:6],
                r_lfsr[7] ^ r_lfsr[26],
                r_lfsr[8] ^ r_lfsr[26],
                r_lfsr[9:25]};
    end
  end

  assign w_seed = (cmd_seed == '0) ? 26'd1 : cmd_seed;

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_rem_nxt   = r_rem;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_lfsr_nxt  = w_seed;
          w_rem_nxt   = cmd_len;
          w_state_nxt = (cmd_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (out_ready) begin
          w_lfsr_nxt = w_step;
          w_rem_nxt  = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // an abort landing in DONE cancels the completion pulse
  assign cmd_ready = (r_state == S_IDLE);
  assign out_valid = (r_state == S_RUN);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE) && !abort;
  assign out_data  = r_lfsr;

endmodule
